// File: rtl/operand_fetch_pkg.sv
// ---------------------------------------------------------------------------
// operand_fetch_pkg
//
// Shared core definitions for the operand fetch stage: datapath widths, the
// operand bundle carried from fetch to execute, and the operand select helper.
//
// Configuration macro: OPFETCH_BYPASS_EN
//   defined   -> a writeback landing in the same cycle as an issue satisfies
//                a pending source and its data is forwarded to the operand.
//   undefined -> a pending source stalls through its writeback cycle and the
//                operand is always taken from the register file.
// ---------------------------------------------------------------------------
package operand_fetch_pkg;

  localparam int XLEN      = 32;
  localparam int REG_IDX_W = 5;
  localparam int NUM_REGS  = 32;

`ifdef OPFETCH_BYPASS_EN
  localparam bit BYPASS_EN = 1'b1;
`else
  localparam bit BYPASS_EN = 1'b0;
`endif

  // Everything the execute stage needs from one issued instruction.
  typedef struct packed {
    logic [XLEN-1:0]      rs1_data;
    logic [XLEN-1:0]      rs2_data;
    logic [REG_IDX_W-1:0] rd_index;
    logic                 rd_wen;
    logic [XLEN-1:0]      pc;
  } operand_bundle_t;

  // True when a writeback this cycle targets a real register equal to idx and
  // forwarding is compiled in. Register 0 never forwards.
  function automatic logic wb_hit(
    input logic [REG_IDX_W-1:0] idx,
    input logic                 wb_en,
    input logic [REG_IDX_W-1:0] wb_idx
  );
    return BYPASS_EN && wb_en && (wb_idx == idx) && (idx != '0);
  endfunction

  // Operand selection: x0 reads as zero, a same-cycle writeback wins over the
  // register file (only when forwarding is compiled in), else register file.
  function automatic logic [XLEN-1:0] select_operand(
    input logic [REG_IDX_W-1:0] idx,
    input logic                 wb_en,
    input logic [REG_IDX_W-1:0] wb_idx,
    input logic [XLEN-1:0]      wb_data,
    input logic [XLEN-1:0]      rf_data
  );
    logic [XLEN-1:0] result;
    if (idx == '0)
      result = '0;
    else if (wb_hit(idx, wb_en, wb_idx))
      result = wb_data;
    else
      result = rf_data;
    return result;
  endfunction

endpackage

// File: rtl/operand_fetch_scoreboard.sv
// ---------------------------------------------------------------------------
// op_scoreboard
//
// Tracks which architectural registers have a write outstanding and reports
// whether the instruction presented for issue must wait.
// Honours OPFETCH_BYPASS_EN through operand_fetch_pkg::BYPASS_EN.
//
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   in_valid                 an instruction is presented for issue
//   rs1_index, rs2_index     its source registers
//   rd_index, rd_wen         its destination and whether it writes it
//   wb_en, wb_rd_index       writeback retiring a destination this cycle
//   set_en, set_index        mark a destination pending (issue accepted)
//   drop_en, drop_index      release a destination of a flushed entry
//   hazard                   issue must not be accepted this cycle
//   pend                     current pending mask (bit 0 always 0)
// ---------------------------------------------------------------------------
module op_scoreboard
  import operand_fetch_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [REG_IDX_W-1:0] rs1_index,
  input  logic [REG_IDX_W-1:0] rs2_index,
  input  logic [REG_IDX_W-1:0] rd_index,
  input  logic                 rd_wen,
  input  logic                 wb_en,
  input  logic [REG_IDX_W-1:0] wb_rd_index,
  input  logic                 set_en,
  input  logic [REG_IDX_W-1:0] set_index,
  input  logic                 drop_en,
  input  logic [REG_IDX_W-1:0] drop_index,
  output logic                 hazard,
  output logic [NUM_REGS-1:0]  pend
);

  logic [NUM_REGS-1:0] pend_q;
  logic [NUM_REGS-1:0] pend_d;
  logic                rs1_busy;
  logic                rs2_busy;
  logic                rd_busy;

  // A source pending only on the writeback happening right now is already
  // satisfied when forwarding exists. The destination check is never masked:
  // a write-after-write must wait for the older write to retire first.
  always_comb begin
    rs1_busy = pend_q[rs1_index] && !wb_hit(rs1_index, wb_en, wb_rd_index);
    rs2_busy = pend_q[rs2_index] && !wb_hit(rs2_index, wb_en, wb_rd_index);
    rd_busy  = rd_wen && pend_q[rd_index];
    hazard   = in_valid && (rs1_busy || rs2_busy || rd_busy);
  end

  // Clears are applied before the set so that a register retired and
  // re-issued in the same cycle stays pending for its new owner.
  always_comb begin
    pend_d = pend_q;
    if (wb_en && (wb_rd_index != '0))
      pend_d[wb_rd_index] = 1'b0;
    if (drop_en && (drop_index != '0))
      pend_d[drop_index] = 1'b0;
    if (set_en && (set_index != '0))
      pend_d[set_index] = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      pend_q <= '0;
    else
      pend_q <= pend_d;
  end

  assign pend = pend_q;

endmodule

// File: rtl/operand_fetch.sv
// ---------------------------------------------------------------------------
// operand_fetch
//
// Issue-side operand fetch stage. Reads source operands from a combinational
// register file, forwards same-cycle writebacks (optional), stalls on
// outstanding register writes and holds one operand bundle for execute behind
// a valid/ready handshake.
// Configuration macro: OPFETCH_BYPASS_EN (see operand_fetch_pkg).
//
// Ports
//   clk, rst                         clock, asynchronous active-low reset
//   in_valid / in_ready              issue handshake
//   in_rs1_index, in_rs2_index       source registers
//   in_rd_index, in_rd_wen           destination and write flag
//   in_pc                            instruction address
//   rf_rs1_index, rf_rs2_index       register file read indices
//   rf_rs1_data, rf_rs2_data         register file read data (same cycle)
//   wb_en, wb_rd_index, wb_data      writeback, coincident with the rf write
//   out_valid / out_ready            execute handshake
//   out_rs1_data, out_rs2_data       fetched operands
//   out_rd_index, out_rd_wen, out_pc carried instruction fields
//   flush                            drop the held entry, block issue
// ---------------------------------------------------------------------------
module operand_fetch
  import operand_fetch_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [REG_IDX_W-1:0] in_rs1_index,
  input  logic [REG_IDX_W-1:0] in_rs2_index,
  input  logic [REG_IDX_W-1:0] in_rd_index,
  input  logic                 in_rd_wen,
  input  logic [XLEN-1:0]      in_pc,
  output logic [REG_IDX_W-1:0] rf_rs1_index,
  output logic [REG_IDX_W-1:0] rf_rs2_index,
  input  logic [XLEN-1:0]      rf_rs1_data,
  input  logic [XLEN-1:0]      rf_rs2_data,
  input  logic                 wb_en,
  input  logic [REG_IDX_W-1:0] wb_rd_index,
  input  logic [XLEN-1:0]      wb_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      out_rs1_data,
  output logic [XLEN-1:0]      out_rs2_data,
  output logic [REG_IDX_W-1:0] out_rd_index,
  output logic                 out_rd_wen,
  output logic [XLEN-1:0]      out_pc,
  input  logic                 flush
);

  logic                out_valid_q;
  operand_bundle_t     out_q;
  operand_bundle_t     next_bundle;
  logic                hazard;
  logic                accept;
  logic                drop_en;
  logic [NUM_REGS-1:0] pend;

  assign rf_rs1_index = in_rs1_index;
  assign rf_rs2_index = in_rs2_index;

  // The output slot frees up either because it is empty or because execute
  // takes it this cycle; a flush always blocks issue for its cycle.
  assign in_ready = !flush && !hazard && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  // A flushed entry never reaches writeback, so its destination must be
  // released here or later readers of that register would stall forever.
  assign drop_en = flush && out_valid_q && out_q.rd_wen;

  op_scoreboard u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .rs1_index   (in_rs1_index),
    .rs2_index   (in_rs2_index),
    .rd_index    (in_rd_index),
    .rd_wen      (in_rd_wen),
    .wb_en       (wb_en),
    .wb_rd_index (wb_rd_index),
    .set_en      (accept && in_rd_wen),
    .set_index   (in_rd_index),
    .drop_en     (drop_en),
    .drop_index  (out_q.rd_index),
    .hazard      (hazard),
    .pend        (pend)
  );

  always_comb begin
    next_bundle.rs1_data = select_operand(in_rs1_index, wb_en, wb_rd_index,
                                          wb_data, rf_rs1_data);
    next_bundle.rs2_data = select_operand(in_rs2_index, wb_en, wb_rd_index,
                                          wb_data, rf_rs2_data);
    next_bundle.rd_index = in_rd_index;
    next_bundle.rd_wen   = in_rd_wen;
    next_bundle.pc       = in_pc;
  end

  // Payload only changes on accept, so it stays frozen while execute stalls.
  // A new accept in the same cycle as a drain simply replaces the entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_q       <= next_bundle;
    end else if (flush || out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_rs1_data = out_q.rs1_data;
  assign out_rs2_data = out_q.rs2_data;
  assign out_rd_index = out_q.rd_index;
  assign out_rd_wen   = out_q.rd_wen;
  assign out_pc       = out_q.pc;

endmodule

// File: tb/tb_operand_fetch.sv
// ---------------------------------------------------------------------------
// tb_operand_fetch
//
// Directed bench for operand_fetch. Acts as the register file (each register
// i holds i*0x11 after reset, writebacks update it at the clock edge) and
// drives a linear sequence of issue, writeback, stall, flush and reset steps.
// Honours OPFETCH_BYPASS_EN to expect the matching RAW timing.
// ---------------------------------------------------------------------------
module tb_operand_fetch;
  import operand_fetch_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 in_valid;
  logic                 in_ready;
  logic [REG_IDX_W-1:0] in_rs1_index;
  logic [REG_IDX_W-1:0] in_rs2_index;
  logic [REG_IDX_W-1:0] in_rd_index;
  logic                 in_rd_wen;
  logic [XLEN-1:0]      in_pc;
  logic [REG_IDX_W-1:0] rf_rs1_index;
  logic [REG_IDX_W-1:0] rf_rs2_index;
  logic [XLEN-1:0]      rf_rs1_data;
  logic [XLEN-1:0]      rf_rs2_data;
  logic                 wb_en;
  logic [REG_IDX_W-1:0] wb_rd_index;
  logic [XLEN-1:0]      wb_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [XLEN-1:0]      out_rs1_data;
  logic [XLEN-1:0]      out_rs2_data;
  logic [REG_IDX_W-1:0] out_rd_index;
  logic                 out_rd_wen;
  logic [XLEN-1:0]      out_pc;
  logic                 flush;

  logic [XLEN-1:0] rf_mem [NUM_REGS];
  int n_asserts = 0;
  int n_fail    = 0;

  operand_fetch dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_rs1_index (in_rs1_index),
    .in_rs2_index (in_rs2_index),
    .in_rd_index  (in_rd_index),
    .in_rd_wen    (in_rd_wen),
    .in_pc        (in_pc),
    .rf_rs1_index (rf_rs1_index),
    .rf_rs2_index (rf_rs2_index),
    .rf_rs1_data  (rf_rs1_data),
    .rf_rs2_data  (rf_rs2_data),
    .wb_en        (wb_en),
    .wb_rd_index  (wb_rd_index),
    .wb_data      (wb_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_rs1_data (out_rs1_data),
    .out_rs2_data (out_rs2_data),
    .out_rd_index (out_rd_index),
    .out_rd_wen   (out_rd_wen),
    .out_pc       (out_pc),
    .flush        (flush)
  );

  always #5 clk = ~clk;

  // Register file model: combinational read, write at the writeback edge.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++)
        rf_mem[i] <= 32'(i) * 32'h11;
    end else if (wb_en && (wb_rd_index != '0)) begin
      rf_mem[wb_rd_index] <= wb_data;
    end
  end

  assign rf_rs1_data = rf_mem[rf_rs1_index];
  assign rf_rs2_data = rf_mem[rf_rs2_index];

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    n_asserts++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic issue(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic wen, input logic [31:0] pc);
    in_valid     = v;
    in_rs1_index = rs1;
    in_rs2_index = rs2;
    in_rd_index  = rd;
    in_rd_wen    = wen;
    in_pc        = pc;
  endtask

  task automatic writeback(input logic en, input logic [4:0] idx, input logic [31:0] data);
    wb_en       = en;
    wb_rd_index = idx;
    wb_data     = data;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0);
    writeback(1'b0, 5'd0, 32'h0);
    out_ready = 1'b1;
    flush     = 1'b0;

    // Reset state, applied asynchronously
    #1 rst = 1'b0;
    #1;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_pend", dut.u_scoreboard.pend_q, 32'h0);
    check("reset_out_pc", out_pc, 32'h0);
    check("reset_out_rs1", out_rs1_data, 32'h0);
    check("reset_out_rd", 32'(out_rd_index), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Basic issue: x1/x2 read, x3 becomes pending
    @(negedge clk);
    issue(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 32'h100);
    #1;
    check("basic_in_ready", 32'(in_ready), 32'd1);
    check("rf_rs1_index", 32'(rf_rs1_index), 32'd1);
    check("rf_rs2_index", 32'(rf_rs2_index), 32'd2);
    after_edge();
    check("basic_out_valid", 32'(out_valid), 32'd1);
    check("basic_rs1", out_rs1_data, 32'h11);
    check("basic_rs2", out_rs2_data, 32'h22);
    check("basic_rd", 32'(out_rd_index), 32'd3);
    check("basic_rd_wen", 32'(out_rd_wen), 32'd1);
    check("basic_pc", out_pc, 32'h100);
    check("basic_pend", dut.u_scoreboard.pend_q, 32'h8);
    @(negedge clk);
    issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0);
    after_edge();
    check("drain_out_valid", 32'(out_valid), 32'd0);

    // RAW on x3 while its writeback lands
    @(negedge clk);
    issue(1'b1, 5'd3, 5'd0, 5'd4, 1'b1, 32'h104);
    writeback(1'b1, 5'd3, 32'hABCD);
    #1;
`ifdef OPFETCH_BYPASS_EN
    check("raw_in_ready", 32'(in_ready), 32'd1);
    after_edge();
`else
    check("raw_stall_in_ready", 32'(in_ready), 32'd0);
    after_edge();
    check("raw_stall_out_valid", 32'(out_valid), 32'd0);
    check("raw_stall_pend", dut.u_scoreboard.pend_q, 32'h0);
    @(negedge clk);
    writeback(1'b0, 5'd0, 32'h0);
    #1;
    check("raw_retry_in_ready", 32'(in_ready), 32'd1);
    after_edge();
`endif
    check("raw_out_valid", 32'(out_valid), 32'd1);
    check("raw_rs1", out_rs1_data, 32'hABCD);
    check("raw_rs2_x0", out_rs2_data, 32'h0);
    check("raw_pend", dut.u_scoreboard.pend_q, 32'h10);
    @(negedge clk);
    issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0);
    writeback(1'b1, 5'd4, 32'h44);
    after_edge();
    check("wb4_out_valid", 32'(out_valid), 32'd0);
    check("wb4_pend", dut.u_scoreboard.pend_q, 32'h0);

    // Backpressure: entry held for 4 cycles, then exactly one accept
    @(negedge clk);
    writeback(1'b0, 5'd0, 32'h0);
    out_ready = 1'b0;
    issue(1'b1, 5'd1, 5'd2, 5'd6, 1'b1, 32'h200);
    after_edge();
    check("bp_out_valid", 32'(out_valid), 32'd1);
    check("bp_pend", dut.u_scoreboard.pend_q, 32'h40);
    @(negedge clk);
    issue(1'b1, 5'd7, 5'd8, 5'd9, 1'b1, 32'h300);
    for (int k = 0; k < 4; k++) begin
      #1;
      check("bp_in_ready", 32'(in_ready), 32'd0);
      after_edge();
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_pc", out_pc, 32'h200);
      check("bp_hold_rd", 32'(out_rd_index), 32'd6);
      check("bp_hold_rs1", out_rs1_data, 32'h11);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", 32'(in_ready), 32'd1);
    after_edge();
    check("bp_new_pc", out_pc, 32'h300);
    check("bp_new_rs1", out_rs1_data, 32'h77);
    check("bp_new_rs2", out_rs2_data, 32'h88);
    check("bp_new_rd", 32'(out_rd_index), 32'd9);
    check("bp_new_pend", dut.u_scoreboard.pend_q, 32'h240);
    @(negedge clk);
    issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0);
    after_edge();
    check("bp_single_accept", 32'(out_valid), 32'd0);

    // Flush of a held entry writing x5
    @(negedge clk);
    out_ready = 1'b0;
    issue(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 32'h400);
    after_edge();
    check("fl_pend_before", dut.u_scoreboard.pend_q, 32'h260);
    @(negedge clk);
    flush = 1'b1;
    issue(1'b1, 5'd1, 5'd2, 5'd10, 1'b1, 32'h500);
    #1;
    check("fl_in_ready", 32'(in_ready), 32'd0);
    after_edge();
    check("fl_out_valid", 32'(out_valid), 32'd0);
    check("fl_pend_after", dut.u_scoreboard.pend_q, 32'h240);

    // Destination x0 and a writeback to x0
    @(negedge clk);
    flush     = 1'b0;
    out_ready = 1'b1;
    issue(1'b1, 5'd0, 5'd2, 5'd0, 1'b1, 32'h600);
    writeback(1'b1, 5'd0, 32'hFFFF);
    #1;
    check("x0_in_ready", 32'(in_ready), 32'd1);
    after_edge();
    check("x0_out_valid", 32'(out_valid), 32'd1);
    check("x0_rs1", out_rs1_data, 32'h0);
    check("x0_rs2", out_rs2_data, 32'h22);
    check("x0_pend", dut.u_scoreboard.pend_q, 32'h240);

    // Hazard detection: pending source, pending destination, no rd write
    @(negedge clk);
    writeback(1'b0, 5'd0, 32'h0);
    issue(1'b1, 5'd6, 5'd2, 5'd12, 1'b1, 32'h610);
    #1;
    check("hz_src_in_ready", 32'(in_ready), 32'd0);
    issue(1'b1, 5'd1, 5'd2, 5'd9, 1'b1, 32'h610);
    #1;
    check("hz_waw_in_ready", 32'(in_ready), 32'd0);
    issue(1'b1, 5'd1, 5'd2, 5'd9, 1'b0, 32'h610);
    #1;
    check("hz_nowen_in_ready", 32'(in_ready), 32'd1);
    issue(1'b0, 5'd6, 5'd2, 5'd9, 1'b1, 32'h610);
    #1;
    check("hz_idle_in_ready", 32'(in_ready), 32'd1);
    after_edge();
    check("hz_out_valid", 32'(out_valid), 32'd0);

    // Same-cycle set and clear of x11 leaves it pending
    @(negedge clk);
    issue(1'b1, 5'd1, 5'd2, 5'd11, 1'b1, 32'h620);
    writeback(1'b1, 5'd11, 32'h1111);
    after_edge();
    check("setclr_pend", dut.u_scoreboard.pend_q, 32'hA40);

    // Retire x6, x9, x11
    @(negedge clk);
    issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0);
    writeback(1'b1, 5'd6, 32'h0);
    @(negedge clk);
    writeback(1'b1, 5'd9, 32'h0);
    @(negedge clk);
    writeback(1'b1, 5'd11, 32'h0);
    after_edge();
    check("retire_pend", dut.u_scoreboard.pend_q, 32'h0);

    // Reset asserted mid-stall with x3 and x5 pending
    @(negedge clk);
    writeback(1'b0, 5'd0, 32'h0);
    issue(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 32'h700);
    @(negedge clk);
    issue(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 32'h704);
    after_edge();
    check("mid_pend", dut.u_scoreboard.pend_q, 32'h28);
    @(negedge clk);
    out_ready = 1'b0;
    issue(1'b1, 5'd3, 5'd2, 5'd7, 1'b1, 32'h708);
    #1;
    check("mid_stall_in_ready", 32'(in_ready), 32'd0);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_pend", dut.u_scoreboard.pend_q, 32'h0);
    check("mid_rst_out_pc", out_pc, 32'h0);
    check("mid_rst_out_rs1", out_rs1_data, 32'h0);
    check("mid_rst_out_rd", 32'(out_rd_index), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    after_edge();
    check("resume_out_valid", 32'(out_valid), 32'd1);
    check("resume_out_pc", out_pc, 32'h708);
    check("resume_out_rs1", out_rs1_data, 32'h33);
    check("resume_pend", dut.u_scoreboard.pend_q, 32'h80);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 SHALL have port: clk  in  1  rising-edge clock, sole clock domain.
REQ-002 SHALL have port: rst  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: in_valid in 1, in_ready out 1 (issue handshake); in_rs1_index, in_rs2_index, in_rd_index in 5 each; in_rd_wen in 1 (instr writes rd); in_pc in 32.
REQ-004 SHALL have ports: rf_rs1_index, rf_rs2_index out 5 (register file read indices); rf_rs1_data, rf_rs2_data in 32 (combinational read data).
REQ-005 SHALL have ports: wb_en in 1, wb_rd_index in 5, wb_data in 32 (writeback port, same cycle as register file write).
REQ-006 SHALL have ports: out_valid out 1, out_ready in 1; out_rs1_data, out_rs2_data out 32; out_rd_index out 5; out_rd_wen out 1; out_pc out 32.
REQ-007 SHALL have port: flush in 1 (discard held entry, block issue this cycle).

Function
REQ-008 SHALL drive rf_rs1_index/rf_rs2_index combinationally from in_rs1_index/in_rs2_index.
REQ-009 SHALL keep a 32-bit pending mask; bit 0 permanently 0.
REQ-010 SHALL compute hazard = in_valid and (pend[rs1] or pend[rs2] or (in_rd_wen and pend[rd])), with a source bit masked when wb_en and wb_rd_index equals that source (bypass, REQ-024).
REQ-011 SHALL assert in_ready = !flush and !hazard and (!out_valid or out_ready).
REQ-012 SHALL accept on in_valid and in_ready; at that clk edge load output register, set out_valid=1.
REQ-013 SHALL select operand data: index 0 -> 0; else wb_en and wb_rd_index==index -> wb_data; else rf data.
REQ-014 SHALL set pend[in_rd_index] on accept when in_rd_wen and in_rd_index!=0.
REQ-015 SHALL clear pend[wb_rd_index] when wb_en and wb_rd_index!=0.
REQ-016 SHALL, on same-cycle set and clear of one index, leave the bit set.
REQ-017 SHALL clear out_valid on out_valid and out_ready with no new accept; latency issue->out_valid exactly 1 cycle.
REQ-018 SHALL hold all out_* stable while out_valid and !out_ready.
REQ-019 SHALL, on flush, clear out_valid next edge and clear pend[out_rd_index] if held entry had out_rd_wen; other pend bits untouched.
REQ-020 SHALL ignore wb_en with wb_rd_index 0 for pending and bypass.

Reset
REQ-021 SHALL on rst low immediately force out_valid=0, pend=0, out_rs1_data=out_rs2_data=0, out_rd_index=0, out_rd_wen=0, out_pc=0.
REQ-022 SHALL drop any held entry when reset asserts mid-operation; in_ready evaluates from reset state.
REQ-023 SHALL resume accepting on first clk edge after rst deasserts.

Configuration
REQ-024 SHALL honour macro OPFETCH_BYPASS_EN: defined -> writeback bypass per REQ-010/REQ-013.
REQ-025 SHALL, without OPFETCH_BYPASS_EN, stall while a source is pending even during its writeback cycle and use rf data directly (1 extra cycle per RAW).

Structure
REQ-026 SHALL take XLEN=32, REG_IDX_W=5, NUM_REGS=32 and the operand bundle struct (rs1/rs2 data, rd index, rd_wen, pc) from the shared core package.
REQ-027 SHALL place the pending mask with set/clear/query logic in sub-module op_scoreboard.

Verification
REQ-028 SHALL cover: reset, issue rs1=1 rs2=2 rd=3 wen, rf returns 0x11/0x22 -> next cycle out_valid=1, data 0x11/0x22, pend[3]=1.
REQ-029 SHALL cover: pend[3]=1, issue rs1=3 with wb_en rd=3 data 0xABCD same cycle -> accepted, out_rs1_data=0xABCD (bypass on); without macro -> stall 1 cycle, then rf data.
REQ-030 SHALL cover: out_valid=1, out_ready=0 for 4 cycles -> in_ready=0, outputs stable, then single accept when out_ready=1.
REQ-031 SHALL cover: held entry rd=5 wen, flush=1 -> out_valid=0, pend[5]=0, no accept that cycle.
REQ-032 SHALL cover: issue rd=0 wen, rs1=0 with wb_en rd=0 data 0xFFFF -> pend unchanged, out_rs1_data=0.
REQ-033 SHALL cover: rst low mid-stall with pend=0x28 -> out_valid=0, pend=0 asynchronously.
